// File: rtl/baccarat_pkg.sv
// Shared types and card helpers for the baccarat dealing controller.
package baccarat_pkg;

    // One state per committed card or per draw decision, plus the final result.
    typedef enum logic [3:0] {
        S_P1     = 4'd0,
        S_D1     = 4'd1,
        S_P2     = 4'd2,
        S_D2     = 4'd3,
        S_EVAL1  = 4'd4,
        S_P3     = 4'd5,
        S_EVAL2  = 4'd6,
        S_D3     = 4'd7,
        S_RESULT = 4'd8
    } state_t;

    // Code 0 means the player has no third card.
    localparam logic [3:0] CARD_NONE    = 4'd0;
    // Dealer totals at or above this always stand, whatever the player drew.
    localparam logic [3:0] BANKER_STAND = 4'd7;

    // Ace..nine keep their face value; tens, court cards, "none" and the
    // unused codes 14/15 all count as zero.
    function automatic logic [3:0] card_value(input logic [3:0] code);
        if (code >= 4'd1 && code <= 4'd9) begin
            return code;
        end
        return CARD_NONE;
    endfunction

endpackage

// File: rtl/deal_sequencer_if.sv
// Bundle of signals between the dealing controller and the card datapath.
// The controller is the master: it drives the load enables and the result
// indicators, and it reads back the scores and the player's third card.
interface deal_sequencer_if;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic       player_win_light;
    logic       dealer_win_light;
    logic [2:0] cards_dealt;
    logic       hand_done;

    modport master (
        input  pscore, dscore, pcard3,
        output load_pcard1, load_pcard2, load_pcard3,
        output load_dcard1, load_dcard2, load_dcard3,
        output player_win_light, dealer_win_light, cards_dealt, hand_done
    );

    modport slave (
        output pscore, dscore, pcard3,
        input  load_pcard1, load_pcard2, load_pcard3,
        input  load_dcard1, load_dcard2, load_dcard3,
        input  player_win_light, dealer_win_light, cards_dealt, hand_done
    );
endinterface

// File: rtl/banker_rule.sv
// Dealer third-card rule: decides from the dealer total and the value of the
// player's third card whether the dealer takes a third card.
module banker_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] p3value,
    output logic       draw
);

    // Low totals always draw, 7 and above (including out-of-range totals)
    // stand, and 3..6 depend on what the player's third card was worth.
    always_comb begin
        draw = 1'b0;
        if (dscore < BANKER_STAND) begin
            case (dscore)
                4'd0, 4'd1, 4'd2: draw = 1'b1;
                4'd3:             draw = (p3value != 4'd8);
                4'd4:             draw = (p3value >= 4'd2) && (p3value <= 4'd7);
                4'd5:             draw = (p3value >= 4'd4) && (p3value <= 4'd7);
                4'd6:             draw = (p3value >= 4'd6) && (p3value <= 4'd7);
                default:          draw = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/deal_sequencer.sv
// Baccarat dealing controller. Each slow_clock edge commits one card or one
// draw decision; the datapath captures a card on the edge that leaves the
// state whose load enable is high.
module deal_sequencer
    import baccarat_pkg::*;
#(
    parameter int NATURAL_MIN      = 8,
    parameter int PLAYER_STAND_MIN = 6
) (
    input  logic             slow_clock,
    input  logic             reset,
    deal_sequencer_if.master bus
);

    localparam logic [3:0] NATURAL_MIN_4  = 4'(NATURAL_MIN);
    localparam logic [3:0] PLAYER_STAND_4 = 4'(PLAYER_STAND_MIN);

    // Load enable vector order: {pcard1, dcard1, pcard2, dcard2, pcard3, dcard3}
    localparam logic [5:0] LOAD_P1 = 6'b100000;

    state_t     r_state;
    state_t     w_nextState;
    logic [5:0] r_loads;
    logic [2:0] r_cardsDealt;
    logic       r_handDone;
    logic [3:0] w_p3Value;
    logic       w_bankerDraw;
    logic       w_inLoadState;
    logic       w_stateLegal;

    // Only one enable per state, so the outputs can never overlap.
    function automatic logic [5:0] loadsFor(input state_t s);
        case (s)
            S_P1:    return 6'b100000;
            S_D1:    return 6'b010000;
            S_P2:    return 6'b001000;
            S_D2:    return 6'b000100;
            S_P3:    return 6'b000010;
            S_D3:    return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    assign w_p3Value = card_value(bus.pcard3);

    banker_rule u_bankerRule (
        .dscore  (bus.dscore),
        .p3value (w_p3Value),
        .draw    (w_bankerDraw)
    );

    assign w_inLoadState = r_state inside {S_P1, S_D1, S_P2, S_D2, S_P3, S_D3};
    assign w_stateLegal  = r_state inside {S_P1, S_D1, S_P2, S_D2, S_EVAL1,
                                           S_P3, S_EVAL2, S_D3, S_RESULT};

    // Next-state decision. Naturals end the hand at once; otherwise the player
    // draws below the stand threshold, and a standing player lets the dealer
    // draw on 5 or less. Any unknown encoding restarts the hand.
    always_comb begin
        w_nextState = S_P1;
        case (r_state)
            S_P1:    w_nextState = S_D1;
            S_D1:    w_nextState = S_P2;
            S_P2:    w_nextState = S_D2;
            S_D2:    w_nextState = S_EVAL1;
            S_EVAL1: begin
                if (bus.pscore >= NATURAL_MIN_4 || bus.dscore >= NATURAL_MIN_4) begin
                    w_nextState = S_RESULT;
                end else if (bus.pscore < PLAYER_STAND_4) begin
                    w_nextState = S_P3;
                end else if (bus.dscore <= 4'd5) begin
                    w_nextState = S_D3;
                end else begin
                    w_nextState = S_RESULT;
                end
            end
            S_P3:     w_nextState = S_EVAL2;
            S_EVAL2:  w_nextState = w_bankerDraw ? S_D3 : S_RESULT;
            S_D3:     w_nextState = S_RESULT;
            S_RESULT: w_nextState = S_RESULT;
            default:  w_nextState = S_P1;
        endcase
    end

    // State register with registered Moore outputs taken from the state being
    // entered; the card counter steps on every edge that leaves a load state.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_P1;
            r_loads      <= LOAD_P1;
            r_cardsDealt <= 3'd0;
            r_handDone   <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_loads    <= loadsFor(w_nextState);
            r_handDone <= (w_nextState == S_RESULT);
            if (!w_stateLegal) begin
                r_cardsDealt <= 3'd0;
            end else if (w_inLoadState && r_cardsDealt != 3'd6) begin
                r_cardsDealt <= r_cardsDealt + 3'd1;
            end
        end
    end

    assign bus.load_pcard1 = r_loads[5];
    assign bus.load_dcard1 = r_loads[4];
    assign bus.load_pcard2 = r_loads[3];
    assign bus.load_dcard2 = r_loads[2];
    assign bus.load_pcard3 = r_loads[1];
    assign bus.load_dcard3 = r_loads[0];
    assign bus.cards_dealt = r_cardsDealt;
    assign bus.hand_done   = r_handDone;

    // Lights follow the live scores, but only once the hand is over; a tie
    // lights both.
    assign bus.player_win_light = r_handDone && (bus.pscore >= bus.dscore);
    assign bus.dealer_win_light = r_handDone && (bus.dscore >= bus.pscore);

endmodule

// File: doc/deal_sequencer.md
Name: deal_sequencer

Overview:
Baccarat dealing controller that drives the six card-load enables of the card datapath and decides third-card draws from the returned player score, dealer score and player third card. It sits directly upstream of the datapath and shares its slow_clock, which is the player's step button. Each slow_clock rising edge commits one card or one decision. At the end of the hand it lights the winner indicators.

Parameters:
NATURAL_MIN, 8, minimum two-card score treated as a natural; the hand ends immediately.
PLAYER_STAND_MIN, 6, player score at or above which the player stands on two cards.

Ports:
slow_clock  input  1  single clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
pscore  input  4  player hand total from the datapath, 0-9
dscore  input  4  dealer hand total from the datapath, 0-9
pcard3  input  4  player third card code: 0 = none, 1-13 = A..K
load_pcard1, load_pcard2, load_pcard3  output  1 each  player card load enables
load_dcard1, load_dcard2, load_dcard3  output  1 each  dealer card load enables
player_win_light  output  1  player wins (or tie)
dealer_win_light  output  1  dealer wins (or tie)
cards_dealt  output  3  number of cards committed so far, 0-6
hand_done  output  1  high in the RESULT state

Behaviour:
- Clock and reset: one clock, slow_clock. Reset is asynchronous and active-high.
- While reset is high: state = S_P1, cards_dealt = 0, all other outputs = 0 except load_pcard1 = 1. This also applies to a reset asserted mid-hand.
- Moore outputs: a load_* enable is high for the whole state. The datapath captures the card on the edge that leaves that state.
- At most one load_* output is high in any cycle.
- States and transitions (one edge each):
  - S_P1 (load_pcard1) -> S_D1 (load_dcard1) -> S_P2 (load_pcard2) -> S_D2 (load_dcard2) -> S_EVAL1.
  - S_EVAL1, no loads; the four cards are now valid:
    - pscore >= NATURAL_MIN or dscore >= NATURAL_MIN -> S_RESULT.
    - else pscore < PLAYER_STAND_MIN -> S_P3.
    - else dscore <= 5 -> S_D3.
    - else -> S_RESULT.
  - S_P3 (load_pcard3) -> S_EVAL2.
  - S_EVAL2, no loads; pcard3 is now valid. If banker_draw(dscore, value(pcard3)) -> S_D3, else -> S_RESULT.
  - S_D3 (load_dcard3) -> S_RESULT.
  - S_RESULT is absorbing until reset.
- Card value: codes 1-9 -> 1-9; codes 0 and 10-13 -> 0.
- banker_draw(d, v):
  - d 0-2: draw.
  - d = 3: draw unless v = 8.
  - d = 4: draw if v in 2..7.
  - d = 5: draw if v in 4..7.
  - d = 6: draw if v in 6..7.
  - d = 7-9: stand.
- cards_dealt: registered; increments by 1 on each edge that leaves a load state; saturates at 6; never changes in S_EVAL1, S_EVAL2 or S_RESULT.
- Win lights are valid only in S_RESULT, computed from the current pscore/dscore:
  - player_win_light = (pscore >= dscore).
  - dealer_win_light = (dscore >= pscore).
  - A tie lights both. Both are 0 in every other state.
- hand_done = 1 only in S_RESULT.
- Score inputs are sampled only in S_EVAL1/S_EVAL2 decisions and in S_RESULT.
- Out-of-range scores (10-15) are treated as stand values; pcard3 codes 14-15 map to value 0.
- Illegal state encodings return to S_P1 on the next edge with cards_dealt = 0.

Decomposition:
- Package baccarat_pkg holds:
  - state_t enum: S_P1, S_D1, S_P2, S_D2, S_EVAL1, S_P3, S_EVAL2, S_D3, S_RESULT.
  - card_value function (4-bit code -> 4-bit value).
  - Constants CARD_NONE = 0 and BANKER_STAND = 7.
- One combinational sub-module, banker_rule: inputs dscore, p3value; output draw. It is unit-testable exhaustively (10x10 table).
- The FSM, counter and win logic stay in deal_sequencer.

Test Plan:
- Reset mid-hand: reset asserted in S_D2 -> outputs drop immediately without a clock edge; load_pcard1 = 1, cards_dealt = 0, lights = 0.
- Natural: pscore = 9, dscore = 3 at S_EVAL1 -> next edge S_RESULT, no load_pcard3/load_dcard3 ever, player_win_light = 1, dealer_win_light = 0, cards_dealt = 4.
- Player stands, dealer draws: pscore = 7, dscore = 4 -> S_D3 with load_dcard3 = 1 for one cycle. Then with dscore = 8 in S_RESULT -> dealer_win_light = 1 only, cards_dealt = 5.
- Player draws, dealer stands: pscore = 3, dscore = 6, pcard3 = 4 (value 4) -> S_P3, S_EVAL2, S_RESULT. load_dcard3 is never high and cards_dealt = 5.
- Player draws, dealer draws: pscore = 2, dscore = 3, pcard3 = 12 (value 0) -> load_dcard3 asserted. With final pscore = dscore = 5 -> both lights = 1, cards_dealt = 6.
- banker_rule exhaustive: all 100 (d, v) pairs match the table, including d = 3/v = 8 (stand), d = 6/v = 6 (draw) and d = 6/v = 5 (stand).
